robs_mult_seq: RTL
==================

ROBS_MULT_SEQ -- requirements
Module: robs_mult_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk edge only.
REQ-004 start  input  1  request to begin a multiplication; sampled in IDLE only.
REQ-005 signed_mode  input  1  1 = two's-complement operands (Robertson), 0 = unsigned; captured with operands.
REQ-006 multiplicand  input  WIDTH  Y operand; captured when start accepted.
REQ-007 multiplier  input  WIDTH  X operand; captured when start accepted.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  single-cycle pulse in DONE state; product valid.
REQ-010 product  output  2*WIDTH  result register; holds value until next completion or reset.

Function
REQ-011 FSM states IDLE, RUN, DONE; encoding free; no other reachable states.
REQ-012 IDLE: start=1 -> capture Y, X, mode; A (WIDTH+1 bits) := 0; iteration counter := 0; next state RUN.
REQ-013 IDLE with start=0: remain IDLE; no register other than FSM changes.
REQ-014 RUN: one iteration per cycle, exactly WIDTH cycles, counter increments each cycle.
REQ-015 Iterations 0..WIDTH-2: if X[0]=1 then A := A + ext(Y), else A unchanged; then {A,X} shifted right one bit.
REQ-016 Final iteration WIDTH-1: signed_mode=1 and X[0]=1 -> A := A - ext(Y) (Robertson correction); signed_mode=0 -> add as REQ-015; then shift.
REQ-017 ext(Y) = sign-extension to WIDTH+1 bits in signed mode, zero-extension in unsigned mode; shift is arithmetic (A[WIDTH] replicated) in signed mode, logical with carry into A[WIDTH] in unsigned mode.
REQ-018 Edge ending final RUN cycle: product := {A[WIDTH-1:0], X}; next state DONE.
REQ-019 DONE lasts exactly one cycle, done=1, then unconditionally IDLE; start during DONE ignored.
REQ-020 Latency: start high in cycle T (IDLE) -> done high in cycle T+WIDTH+1; minimum start-to-start spacing WIDTH+2 cycles.
REQ-021 start, signed_mode and operand changes during RUN/DONE have no effect on the result in progress.
REQ-022 product is exact 2*WIDTH-bit result for all operand pairs, including most-negative × most-negative in signed mode (no overflow possible).
REQ-023 busy=1 iff state RUN; done=1 iff state DONE; both registered-state decodes, no combinational path from start.

Reset
REQ-024 reset=0 at a rising edge -> state IDLE, busy=0, done=0, product=0, A=0, X=0, Y=0, counter=0.
REQ-025 Reset asserted mid-RUN or in DONE aborts the operation; no done pulse is emitted for it.
REQ-026 start sampled in the same cycle as reset=0 is ignored.

Configuration
REQ-027 Macro ROBS_ZERO_SKIP_EN selects zero-operand early termination.
REQ-028 Defined: in IDLE, start=1 with multiplicand=0 or multiplier=0 -> product := 0, next state DONE directly; done in cycle T+1; busy never asserted.
REQ-029 Undefined: zero operands follow the normal RUN path; done in cycle T+WIDTH+1; product 0.

Verification (WIDTH=8)
REQ-030 Signed: Y=8'hFB (-5), X=8'h03, signed_mode=1, start at T -> done at T+9, product=16'hFFF1.
REQ-031 Signed corner: Y=8'h80, X=8'h80 -> product=16'h4000; Y=8'h7F, X=8'h80 -> product=16'hC080.
REQ-032 Unsigned: Y=8'hFF, X=8'hFF, signed_mode=0 -> product=16'hFE01, busy high exactly 8 cycles.
REQ-033 Zero operand: Y=8'h00, X=8'h55 -> with ROBS_ZERO_SKIP_EN done at T+1, busy never high; without, done at T+9; product=16'h0000 both builds.
REQ-034 Reset mid-operation: start (8'h12 × 8'h34), reset=0 at T+4 -> next cycle IDLE, product=0, no done pulse; a following start with 8'h02 × 8'h03 completes with product=16'h0006.
REQ-035 Back-to-back: start held high continuously -> new operation accepted every 10 cycles, each result correct, start during RUN/DONE ignored.

Source files
------------

// File: rtl/robs_mult_seq.sv
// Sequential shift-add multiplier: unsigned, or two's-complement using Robertson's correction.
// Define ROBS_ZERO_SKIP_EN to finish at once when either operand is zero.
module robs_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] x, y;
  logic [CW-1:0]    cnt;
  logic             mode;

  logic             last;
  logic [WIDTH:0]   yext, sum, a_sh;
  logic [WIDTH-1:0] x_sh;

  always_comb begin
    last = (cnt == CW'(WIDTH-1));
    yext = mode ? {y[WIDTH-1], y} : {1'b0, y};
    sum  = a;
    if (x[0]) begin
      // The multiplier's sign bit carries negative weight, so the last partial product is subtracted.
      if (last && mode) sum = a - yext;
      else              sum = a + yext;
    end
    // Unsigned: sum[WIDTH] is the carry and moves down, with a 0 shifted in at the top.
    a_sh = {mode & sum[WIDTH], sum[WIDTH:1]};
    x_sh = {sum[0], x[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a       <= '0;
      x       <= '0;
      y       <= '0;
      cnt     <= '0;
      mode    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            y    <= multiplicand;
            x    <= multiplier;
            mode <= signed_mode;
            a    <= '0;
            cnt  <= '0;
`ifdef ROBS_ZERO_SKIP_EN
            if (multiplicand == '0 || multiplier == '0) begin
              product <= '0;
              state   <= DONE;
              done    <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
`else
            state <= RUN;
            busy  <= 1'b1;
`endif
          end
        end
        RUN: begin
          a   <= a_sh;
          x   <= x_sh;
          cnt <= cnt + 1'b1;
          if (last) begin
            product <= {a_sh[WIDTH-1:0], x_sh};
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
